// File: rtl/radar_burst_controller.sv
// rtl/radar_burst_controller.sv - multi-pulse chirp burst sequencer for the GPR front end
module radar_burst_controller #(
  parameter int CNT_W       = 32,
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int PIDX_W      = 16,
  parameter int TIMEOUT_CYC = 245760
) (
  input  logic              clk_fmc150,
  input  logic              aresetn,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_prp_cycles,
  input  logic [CNT_W-1:0]  cfg_collect_cycles,
  input  logic [PIDX_W-1:0] cfg_pulses,
  input  logic [NUM_CH-1:0] cfg_ch_mask,
  input  logic              start,
  input  logic              stop,
  input  logic              abort,
  input  logic              chirp_ready,
  input  logic              chirp_done,
  output logic              chirp_init,
  output logic              chirp_enable,
  output logic              adc_enable,
  output logic [CH_W-1:0]   ch_sel,
  output logic [PIDX_W-1:0] pulse_idx,
  output logic              busy,
  output logic              burst_done,
  output logic              err_cfg,
  output logic              err_timeout,
  output logic              err_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_PRP, S_CHIRP, S_COLLECT, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  prp_q, collect_q;
  logic [PIDX_W-1:0] pulses_q;
  logic [NUM_CH-1:0] mask_q;
  logic [CNT_W-1:0]  prp_timer, to_timer, col_timer;
  logic              stop_lat;

  logic mode_ok, cfg_ok, accept, reject, fire, last_pulse, timeout_hit, end_burst;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    lowest_set = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (m[k]) lowest_set = CH_W'(k);
  endfunction

  // Nearest enabled channel above cur, wrapping to the lowest enabled one.
  function automatic logic [CH_W-1:0] next_set(input logic [NUM_CH-1:0] m,
                                               input logic [CH_W-1:0] cur);
    next_set = lowest_set(m);
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (m[k] && (k > int'(cur))) next_set = CH_W'(k);
  endfunction

  always_comb begin
    mode_ok     = (cfg_mode == 2'd1) || (cfg_mode == 2'd2);
    cfg_ok      = (cfg_pulses != '0) && (cfg_ch_mask != '0) && (cfg_prp_cycles != '0);
    accept      = (state == S_IDLE) && start && mode_ok && cfg_ok;
    reject      = (state == S_IDLE) && start && mode_ok && !cfg_ok && !abort;
    fire        = ((state == S_ARM) || (state == S_WAIT_PRP)) && (prp_timer == '0) && chirp_ready;
    last_pulse  = (pulse_idx == pulses_q - PIDX_W'(1));
    timeout_hit = (state == S_CHIRP) && !chirp_done && (to_timer <= CNT_W'(1));
    end_burst   = last_pulse && ((mode_q == 2'd1) || stop_lat || stop);
  end

  always_ff @(posedge clk_fmc150) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    chirp_enable = (state == S_CHIRP);
    adc_enable   = (state == S_CHIRP) || (state == S_COLLECT);
    busy         = (state != S_IDLE);
    burst_done   = (state == S_DONE);
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:              if (accept) state_nxt = S_ARM;
        S_ARM, S_WAIT_PRP:   if (fire) state_nxt = S_CHIRP;
        S_CHIRP: begin
          if (chirp_done)       state_nxt = (collect_q == '0) ? S_NEXT : S_COLLECT;
          else if (timeout_hit) state_nxt = S_DONE;
        end
        S_COLLECT:           if (col_timer == '0) state_nxt = S_NEXT;
        S_NEXT:              state_nxt = end_burst ? S_DONE : S_WAIT_PRP;
        S_DONE:              state_nxt = S_IDLE;
        default:             state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_fmc150) begin
    if (!aresetn) begin
      mode_q      <= '0;
      prp_q       <= '0;
      collect_q   <= '0;
      pulses_q    <= '0;
      mask_q      <= '0;
      prp_timer   <= '0;
      to_timer    <= '0;
      col_timer   <= '0;
      stop_lat    <= 1'b0;
      chirp_init  <= 1'b0;
      ch_sel      <= '0;
      pulse_idx   <= '0;
      err_cfg     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      chirp_init <= 1'b0;
      if ((state != S_IDLE) && (prp_timer != '0)) prp_timer <= prp_timer - CNT_W'(1);
      if ((state == S_CHIRP) && (to_timer != '0)) to_timer <= to_timer - CNT_W'(1);
      if ((state == S_COLLECT) && (col_timer != '0)) col_timer <= col_timer - CNT_W'(1);

      if (state == S_IDLE) stop_lat <= 1'b0;
      else if (stop)       stop_lat <= 1'b1;

      if (!abort) begin
        if (reject) err_cfg <= 1'b1;
        if (accept) begin
          mode_q      <= cfg_mode;
          prp_q       <= cfg_prp_cycles;
          collect_q   <= cfg_collect_cycles;
          pulses_q    <= cfg_pulses;
          mask_q      <= cfg_ch_mask;
          prp_timer   <= '0;
          err_cfg     <= 1'b0;
          err_timeout <= 1'b0;
          err_overrun <= 1'b0;
          pulse_idx   <= '0;
          ch_sel      <= lowest_set(cfg_ch_mask);
        end
        if (fire) begin
          chirp_init <= 1'b1;
          prp_timer  <= prp_q - CNT_W'(1);
          to_timer   <= CNT_W'(TIMEOUT_CYC);
        end
        if ((state == S_CHIRP) && chirp_done) col_timer <= collect_q - CNT_W'(1);
        // PRP period ran out before this pulse finished chirping/collecting.
        if (((state == S_CHIRP) || (state == S_COLLECT)) && (prp_timer == CNT_W'(1)))
          err_overrun <= 1'b1;
        if (timeout_hit) err_timeout <= 1'b1;
        if ((state == S_NEXT) && !end_burst) begin
          ch_sel    <= next_set(mask_q, ch_sel);
          pulse_idx <= last_pulse ? '0 : pulse_idx + PIDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_radar_burst_controller.sv
// tb/tb_radar_burst_controller.sv - directed self-checking bench for radar_burst_controller
module tb_radar_burst_controller;

  logic        clk_fmc150, aresetn;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_prp_cycles, cfg_collect_cycles;
  logic [15:0] cfg_pulses;
  logic [3:0]  cfg_ch_mask;
  logic        start, stop, abort, chirp_ready, chirp_done;
  logic        chirp_init, chirp_enable, adc_enable, busy, burst_done;
  logic        err_cfg, err_timeout, err_overrun;
  logic [1:0]  ch_sel;
  logic [15:0] pulse_idx;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, done_dly = 20, last_init = -1000;
  int adc_cnt = 0, bd_cnt = 0, bd_cyc = 0, r = 0, n = 0;
  int init_q[$], pidx_q[$], chs_q[$];

  radar_burst_controller #(
    .CNT_W(32), .NUM_CH(4), .CH_W(2), .PIDX_W(16), .TIMEOUT_CYC(50)
  ) dut (
    .clk_fmc150(clk_fmc150), .aresetn(aresetn), .cfg_mode(cfg_mode),
    .cfg_prp_cycles(cfg_prp_cycles), .cfg_collect_cycles(cfg_collect_cycles),
    .cfg_pulses(cfg_pulses), .cfg_ch_mask(cfg_ch_mask), .start(start), .stop(stop),
    .abort(abort), .chirp_ready(chirp_ready), .chirp_done(chirp_done),
    .chirp_init(chirp_init), .chirp_enable(chirp_enable), .adc_enable(adc_enable),
    .ch_sel(ch_sel), .pulse_idx(pulse_idx), .busy(busy), .burst_done(burst_done),
    .err_cfg(err_cfg), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  initial begin
    clk_fmc150 = 1'b0;
    forever #5 clk_fmc150 = ~clk_fmc150;
  end

  initial forever begin
    @(posedge clk_fmc150);
    cyc++;
  end

  // Monitor plus DAC model: chirp_done arrives done_dly cycles after each chirp_init.
  initial begin
    chirp_done = 1'b0;
    forever begin
      @(negedge clk_fmc150);
      if (chirp_init) begin
        init_q.push_back(cyc);
        pidx_q.push_back(int'(pulse_idx));
        chs_q.push_back(int'(ch_sel));
        last_init = cyc;
      end
      if (adc_enable) adc_cnt++;
      if (burst_done) begin bd_cnt++; bd_cyc = cyc; end
      chirp_done = (done_dly != 0) && (cyc == last_init + done_dly);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk_fmc150);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({chirp_init, chirp_enable, adc_enable, busy, burst_done,
                err_cfg, err_timeout, err_overrun, ch_sel, pulse_idx});
  endfunction

  task automatic run_start(input logic [1:0] m, input int prp, input int col,
                           input int pul, input logic [3:0] mask);
    cfg_mode = m; cfg_prp_cycles = prp; cfg_collect_cycles = col;
    cfg_pulses = 16'(pul); cfg_ch_mask = mask;
    init_q.delete(); pidx_q.delete(); chs_q.delete();
    adc_cnt = 0; bd_cnt = 0; bd_cyc = 0;
    start_cyc = cyc;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 2000) begin tick(); k++; end
    check(tag, 64'(k < 2000), 64'd1);
  endtask

  initial begin
    aresetn = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0; chirp_ready = 1'b1;
    cfg_mode = 2'd0; cfg_prp_cycles = 0; cfg_collect_cycles = 0; cfg_pulses = 0; cfg_ch_mask = 0;
    repeat (3) tick();
    check("reset_outputs", outs(), 64'd0);
    aresetn = 1'b1;
    tick();

    // Single burst, three pulses over mask 1011
    run_start(2'd1, 100, 10, 3, 4'b1011);
    wait_idle("t1_idle");
    check("t1_init_count", init_q.size(), 3);
    check("t1_first_latency", init_q[0], start_cyc + 2);
    check("t1_spacing1", init_q[1] - init_q[0], 100);
    check("t1_spacing2", init_q[2] - init_q[0], 200);
    check("t1_ch_seq", {chs_q[0][3:0], chs_q[1][3:0], chs_q[2][3:0]}, 12'h013);
    check("t1_pidx_seq", {pidx_q[0][3:0], pidx_q[1][3:0], pidx_q[2][3:0]}, 12'h012);
    check("t1_adc_cycles", adc_cnt, 93);
    check("t1_burst_done_count", bd_cnt, 1);
    check("t1_burst_done_cycle", bd_cyc, init_q[0] + 232);
    check("t1_flags", {err_cfg, err_timeout, err_overrun}, 3'b000);

    // Continuous mode, stop during the fifth pulse ends after that burst
    run_start(2'd2, 60, 5, 2, 4'b0100);
    n = 0;
    while (init_q.size() < 5 && n < 2000) begin tick(); n++; end
    check("t2_reached_pulse5", 64'(n < 2000), 64'd1);
    repeat (3) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle("t2_idle");
    check("t2_init_count", init_q.size(), 6);
    check("t2_pidx_seq", {pidx_q[0][3:0], pidx_q[1][3:0], pidx_q[2][3:0],
                          pidx_q[3][3:0], pidx_q[4][3:0], pidx_q[5][3:0]}, 24'h010101);
    check("t2_ch_seq", {chs_q[0][3:0], chs_q[3][3:0], chs_q[5][3:0]}, 12'h222);
    check("t2_span", init_q[5] - init_q[0], 300);
    check("t2_burst_done_count", bd_cnt, 1);
    check("t2_burst_done_cycle", bd_cyc, init_q[5] + 27);

    // PRP shorter than the chirp: overrun, next chirp from first WAIT_PRP cycle
    run_start(2'd1, 15, 0, 2, 4'b0001);
    wait_idle("t3_idle");
    check("t3_init_count", init_q.size(), 2);
    check("t3_spacing", init_q[1] - init_q[0], 23);
    check("t3_overrun", err_overrun, 1'b1);
    check("t3_ch_seq", {chs_q[0][3:0], chs_q[1][3:0]}, 8'h00);

    // chirp_done never arrives: timeout after 50 cycles
    done_dly = 0;
    run_start(2'd1, 100, 10, 1, 4'b0010);
    n = 0;
    while (chirp_init !== 1'b1 && n < 100) begin tick(); n++; end
    check("t4_init_seen", 64'(n < 100), 64'd1);
    check("t4_ch_sel", ch_sel, 2'd1);
    repeat (49) tick();
    check("t4_no_timeout_yet", {err_timeout, chirp_enable}, 2'b01);
    tick();
    check("t4_timeout_done", {err_timeout, burst_done, chirp_enable}, 3'b110);
    tick();
    check("t4_busy_low", busy, 1'b0);
    done_dly = 20;

    // Bad config, ignored mode, abort mid-COLLECT, recovery
    run_start(2'd1, 100, 30, 0, 4'b1000);
    check("t5_bad_cfg", {err_cfg, busy}, 2'b10);
    run_start(2'd0, 100, 30, 1, 4'b1000);
    check("t5_mode0_ignored", {err_cfg, busy}, 2'b10);
    run_start(2'd1, 100, 30, 1, 4'b1000);
    check("t5_cfg_cleared", {err_cfg, busy, ch_sel}, 4'b0111);
    n = 0;
    while (!(adc_enable === 1'b1 && chirp_enable === 1'b0) && n < 200) begin tick(); n++; end
    check("t5_in_collect", 64'(n < 200), 64'd1);
    repeat (5) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("t5_abort_outputs", {adc_enable, chirp_enable, busy, burst_done}, 4'b0000);
    repeat (3) tick();
    check("t5_no_burst_done", bd_cnt, 0);
    run_start(2'd3, 100, 30, 0, 4'b1000);
    check("t5_mode3_ignored", {err_cfg, busy}, 2'b00);
    run_start(2'd1, 100, 0, 0, 4'b1000);
    check("t5_bad_cfg_again", err_cfg, 1'b1);
    run_start(2'd2, 40, 0, 1, 4'b0001);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle("t5_rerun_idle");
    check("t5_rerun", {init_q.size() == 1, bd_cnt == 1, err_cfg}, 3'b110);

    // Reset mid-CHIRP, then chirp_ready gating in ARM
    run_start(2'd1, 100, 10, 2, 4'b0011);
    n = 0;
    while (chirp_enable !== 1'b1 && n < 100) begin tick(); n++; end
    repeat (3) tick();
    aresetn = 1'b0; tick();
    check("t6_reset_mid_chirp", outs(), 64'd0);
    aresetn = 1'b1;
    chirp_ready = 1'b0;
    run_start(2'd1, 100, 10, 1, 4'b0100);
    repeat (10) tick();
    check("t6_held_in_arm", {init_q.size() == 0, busy, chirp_enable}, 3'b110);
    r = cyc;
    chirp_ready = 1'b1; tick();
    check("t6_init_after_ready", {chirp_init, init_q.size() == 1}, 2'b11);
    check("t6_init_cycle", init_q[0], r + 1);
    wait_idle("t6_idle");
    check("t6_burst_done", bd_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
